// File: rtl/mult_array_ctrl.sv
// Handshake controller for a combinational N-bit array multiplier: registers operands,
// waits SETTLE cycles for the array to settle, then captures and offers the 2N-bit product.
module mult_array_ctrl #(
    parameter int unsigned N      = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   m_in,
    input  logic [N-1:0]   q_in,
    output logic [N-1:0]   arr_m,
    output logic [N-1:0]   arr_q,
    input  logic [2*N-1:0] arr_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PW    = 2 * N;

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("mult_array_ctrl: SETTLE must be in 1..255");
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     arr_m_q;
    logic [N-1:0]     arr_q_q;
    logic [PW-1:0]    product_q;
    logic             out_valid_q;

    // Operands only move on accept, so the array never sees a mid-transaction change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            arr_m_q     <= '0;
            arr_q_q     <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        arr_m_q <= m_in;
                        arr_q_q <= q_in;
                        cnt_q   <= CNT_INIT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        product_q   <= arr_p;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake status is a pure state decode, independent of the valid/ready inputs.
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign arr_m     = arr_m_q;
    assign arr_q     = arr_q_q;
    assign product   = product_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mult_array_ctrl.sv
// Directed bench for mult_array_ctrl: N=4/SETTLE=2 main instance plus N=8 instances
// at SETTLE=1 and SETTLE=4, each driving a behavioural array product.
module tb_mult_array_ctrl;

    logic clk;
    logic rst_n;

    // Main instance: N=4, SETTLE=2
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0] m_in, q_in, arr_m, arr_q;
    logic [7:0] arr_p, product;

    // Sweep instances: N=8, SETTLE=1 and SETTLE=4
    logic        iv1, ir1, ov1, or1, bz1;
    logic [7:0]  m1, q1, am1, aq1;
    logic [15:0] ap1, pr1;
    logic        iv4, ir4, ov4, or4, bz4;
    logic [7:0]  m4, q4, am4, aq4;
    logic [15:0] ap4, pr4;

    int checks;
    int failures;

    assign arr_p = 8'(arr_m) * 8'(arr_q);
    assign ap1   = 16'(am1) * 16'(aq1);
    assign ap4   = 16'(am4) * 16'(aq4);

    mult_array_ctrl #(.N(4), .SETTLE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .m_in(m_in), .q_in(q_in), .arr_m(arr_m), .arr_q(arr_q), .arr_p(arr_p),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    mult_array_ctrl #(.N(8), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .m_in(m1), .q_in(q1), .arr_m(am1), .arr_q(aq1), .arr_p(ap1),
        .out_valid(ov1), .out_ready(or1), .product(pr1), .busy(bz1)
    );

    mult_array_ctrl #(.N(8), .SETTLE(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .m_in(m4), .q_in(q4), .arr_m(am4), .arr_q(aq4), .arr_p(ap4),
        .out_valid(ov4), .out_ready(or4), .product(pr4), .busy(bz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] ext_m [3] = '{4'd15, 4'd0, 4'd1};
    logic [3:0] ext_q [3] = '{4'd15, 4'd9, 4'd15};
    logic [7:0] ext_p [3] = '{8'd225, 8'd0, 8'd15};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; m_in = '0; q_in = '0; out_ready = 1'b0;
        iv1 = 1'b0; m1 = '0; q1 = '0; or1 = 1'b0;
        iv4 = 1'b0; m4 = '0; q4 = '0; or4 = 1'b0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: in_ready=%b busy=%b out_valid=%b required 1 0 0",
                     in_ready, busy, out_valid);
        end
        checks++;
        if (arr_m !== 4'd0 || arr_q !== 4'd0 || product !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: arr_m=%0d arr_q=%0d product=%0d required 0 0 0",
                     arr_m, arr_q, product);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid = 1'b1; m_in = 4'd13; q_in = 4'd11;
        step();  // t0 accept
        in_valid = 1'b0;
        checks++;
        if (arr_m !== 4'd13 || arr_q !== 4'd11 || busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_accept: arr_m=%0d arr_q=%0d busy=%b in_ready=%b required 13 11 1 0",
                     arr_m, arr_q, busy, in_ready);
        end
        step();  // t0+1
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid: out_valid=%b required 0", out_valid);
        end
        step();  // t0+2 capture
        checks++;
        if (out_valid !== 1'b1 || product !== 8'd143) begin
            failures++;
            $display("FAIL basic_product: out_valid=%b product=%0d required 1 143", out_valid, product);
        end
        step();  // t0+3 handshake
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || product !== 8'd143) begin
            failures++;
            $display("FAIL basic_idle: out_valid=%b in_ready=%b busy=%b product=%0d required 0 1 0 143",
                     out_valid, in_ready, busy, product);
        end
    endtask

    task automatic test_extremes();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic seen;
            logic stable;
            seen = 1'b0;
            stable = 1'b1;
            in_valid = 1'b1; m_in = ext_m[i]; q_in = ext_q[i];
            step();
            in_valid = 1'b0; m_in = 4'd7; q_in = 4'd7;
            for (int c = 0; c < 10 && !seen; c++) begin
                if (arr_m !== ext_m[i] || arr_q !== ext_q[i]) stable = 1'b0;
                step();
                if (out_valid === 1'b1) seen = 1'b1;
            end
            if (arr_m !== ext_m[i] || arr_q !== ext_q[i]) stable = 1'b0;
            checks++;
            if (!seen || product !== ext_p[i]) begin
                failures++;
                $display("FAIL extreme_product[%0d]: seen=%b product=%0d required 1 %0d",
                         i, seen, product, ext_p[i]);
            end
            checks++;
            if (!stable) begin
                failures++;
                $display("FAIL extreme_operand_hold[%0d]: arr_m=%0d arr_q=%0d required %0d %0d",
                         i, arr_m, arr_q, ext_m[i], ext_q[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic held;
        held = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1; m_in = 4'd6; q_in = 4'd7;
        step();
        in_valid = 1'b0;
        step();
        step();
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || product !== 8'd42 || in_ready !== 1'b0) held = 1'b0;
            step();
        end
        checks++;
        if (!held || out_valid !== 1'b1 || product !== 8'd42) begin
            failures++;
            $display("FAIL backpressure_hold: out_valid=%b product=%0d in_ready=%b required 1 42 0",
                     out_valid, product, in_ready);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 8'd42) begin
            failures++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b product=%0d required 0 1 42",
                     out_valid, in_ready, product);
        end
    endtask

    task automatic test_ignored_input();
        out_ready = 1'b1;
        in_valid = 1'b1; m_in = 4'd5; q_in = 4'd5;
        step();  // t0 accept 5x5
        m_in = 4'd3; q_in = 4'd3;
        in_valid = 1'b0;
        step();  // t0+1
        in_valid = 1'b1;
        checks++;
        if (arr_m !== 4'd5 || arr_q !== 4'd5) begin
            failures++;
            $display("FAIL ignored_wait: arr_m=%0d arr_q=%0d required 5 5", arr_m, arr_q);
        end
        step();  // t0+2 capture
        checks++;
        if (out_valid !== 1'b1 || product !== 8'd25 || arr_m !== 4'd5) begin
            failures++;
            $display("FAIL ignored_product: out_valid=%b product=%0d arr_m=%0d required 1 25 5",
                     out_valid, product, arr_m);
        end
        step();  // t0+3 handshake
        checks++;
        if (in_ready !== 1'b1 || arr_m !== 4'd5) begin
            failures++;
            $display("FAIL ignored_idle: in_ready=%b arr_m=%0d required 1 5", in_ready, arr_m);
        end
        step();  // t0+4 accept 3x3
        in_valid = 1'b0;
        checks++;
        if (arr_m !== 4'd3 || arr_q !== 4'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ignored_late_accept: arr_m=%0d arr_q=%0d busy=%b required 3 3 1",
                     arr_m, arr_q, busy);
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || product !== 8'd9) begin
            failures++;
            $display("FAIL ignored_second_product: out_valid=%b product=%0d required 1 9",
                     out_valid, product);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic pulse;
        pulse = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; m_in = 4'd9; q_in = 4'd9;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (arr_m !== 4'd0 || arr_q !== 4'd0 || product !== 8'd0 || out_valid !== 1'b0
            || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: arr_m=%0d arr_q=%0d product=%0d out_valid=%b in_ready=%b busy=%b required 0 0 0 0 1 0",
                     arr_m, arr_q, product, out_valid, in_ready, busy);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) pulse = 1'b1;
        end
        checks++;
        if (pulse) begin
            failures++;
            $display("FAIL reset_no_emit: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_settle_sweep();
        int lat1;
        int lat4;
        logic [15:0] p1;
        logic [15:0] p4;
        lat1 = -1; lat4 = -1; p1 = '0; p4 = '0;
        or1 = 1'b1; or4 = 1'b1;
        iv1 = 1'b1; m1 = 8'd200; q1 = 8'd255;
        iv4 = 1'b1; m4 = 8'd200; q4 = 8'd255;
        step();  // accept on both
        iv1 = 1'b0; iv4 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (ov1 === 1'b1 && lat1 < 0) begin lat1 = k; p1 = pr1; end
            if (ov4 === 1'b1 && lat4 < 0) begin lat4 = k; p4 = pr4; end
        end
        checks++;
        if (lat1 != 1 || p1 !== 16'd51000) begin
            failures++;
            $display("FAIL sweep_settle1: latency=%0d product=%0d required 1 51000", lat1, p1);
        end
        checks++;
        if (lat4 != 4 || p4 !== 16'd51000) begin
            failures++;
            $display("FAIL sweep_settle4: latency=%0d product=%0d required 4 51000", lat4, p4);
        end
        checks++;
        if (ir1 !== 1'b1 || ir4 !== 1'b1 || ov1 !== 1'b0 || ov4 !== 1'b0) begin
            failures++;
            $display("FAIL sweep_idle: ir1=%b ir4=%b ov1=%b ov4=%b required 1 1 0 0", ir1, ir4, ov1, ov4);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_ignored_input();
        test_reset_mid();
        test_settle_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_array_ctrl.md
# mult_array_ctrl

Sequential controller wrapped around the combinational N-bit array multiplier, which is built from the first-row and inner-row multiplier cells. It accepts an operand pair over a valid/ready handshake and registers the operands onto the array's m/q inputs. It then waits a fixed number of cycles for the carry chains to settle, captures the 2N-bit product, and presents it downstream over a second valid/ready handshake. It is the only path by which operands reach the array and products leave it, so the array never sees mid-transaction operand changes.

## Interface
- N, 4: operand width in bits; the product is 2N bits.
- SETTLE, 2: cycles the array output is given to settle before capture. Legal range is 1..255; a value of 0 is an elaboration error.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  upstream presents an operand pair.
- in_ready  out  1  controller can accept an operand pair.
- m_in  in  N  multiplicand.
- q_in  in  N  multiplier.
- arr_m  out  N  registered multiplicand driven to the array.
- arr_q  out  N  registered multiplier driven to the array.
- arr_p  in  2N  array product, combinational from arr_m and arr_q.
- out_valid  out  1  product is valid.
- out_ready  in  1  downstream accepts the product.
- product  out  2N  captured product.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, WAIT and DONE.
- Counter cnt is 8 bits wide.

**IDLE**
- in_ready=1.
- On in_valid: arr_m<=m_in, arr_q<=q_in, cnt<=SETTLE-1, go to WAIT.
- If in_valid is low, stay in IDLE.

**WAIT**
- in_ready=0.
- If cnt!=0: cnt<=cnt-1.
- If cnt==0: product<=arr_p, out_valid<=1, go to DONE.

**DONE**
- in_ready=0 and out_valid=1.
- product, arr_m and arr_q are held stable.
- On out_ready: out_valid<=0, go to IDLE.

**Signal rules**
- in_ready and busy are decoded combinationally from state only; neither depends on in_valid or out_ready.
- arr_m and arr_q change only on an accept edge and otherwise hold their last value, including through IDLE.
- product changes only on a capture edge; the last product remains readable after out_valid falls.
- in_valid asserted in WAIT or DONE is ignored and not queued; upstream must hold it until in_ready is seen.
- Arithmetic is unsigned, and product is exactly arr_p as sampled. The controller performs no truncation or sign handling.

**Reset**
- Asserting rst_n low at any time, including mid-WAIT or mid-DONE, immediately forces state=IDLE, cnt=0, arr_m=0, arr_q=0, product=0 and out_valid=0.
- An in-flight transaction is dropped and no product is emitted for it.
- Resulting reset output values: in_ready=1, busy=0.

## Timing
- An accept at edge t0 means arr_m and arr_q are valid from t0+ onward.
- The capture edge is t0+SETTLE, so arr_p has settled for exactly SETTLE full cycles.
- out_valid rises after edge t0+SETTLE; latency from accept to out_valid is SETTLE cycles.
- An output handshake at edge t1 returns the FSM to IDLE; in_ready is high after t1, and the earliest next accept is t1+1.
- Minimum initiation interval is SETTLE+2 cycles, reached when out_ready is held high.
- out_ready asserted while out_valid=0 has no effect.
- Backpressure has no bound: DONE holds indefinitely while out_ready=0.

## Test plan
- **Basic product:** reset, then N=4, SETTLE=2, m_in=13, q_in=11, out_ready=1. Required: accept at t0, out_valid high after t0+2 with product=143 (0x8F), IDLE after t0+3.
- **Extremes:** run 15×15, 0×9 and 1×15. Required: products 225, 0 and 15. arr_m and arr_q must not change between accept and handshake.
- **Backpressure:** capture 6×7 with out_ready=0 for 10 cycles. Required: out_valid, product=42 and in_ready=0 all held for the 10 cycles. Raise out_ready: out_valid drops after one edge and in_ready rises.
- **Ignored input:** toggle in_valid with 3×3 during WAIT of a 5×5 job. Required: product=25, and 3×3 is accepted only once the FSM is back in IDLE.
- **Reset mid-operation:** drop rst_n in WAIT after accepting 9×9. Required: all outputs zero, in_ready=1 immediately, and no out_valid pulse after release.
- **Parameter sweep:** SETTLE=1 and SETTLE=4 with N=8 on 200×255. Required: product=51000 with out_valid latency of 1 and 4 cycles respectively.
